// File: rtl/ddr3_frame_writer_pkg.sv
// Shared constants and types for the DDR3 frame writer: CSR map, FSM states, pixel packing geometry.
package ddr3_frame_writer_pkg;

  localparam int PIX_PER_WORD = 4;
  localparam int PIX_W        = 24;
  localparam int LANE_W       = 32;
  localparam int WORD_W       = PIX_PER_WORD * LANE_W;

  localparam logic [7:0] CSR_CTRL        = 8'd0;
  localparam logic [7:0] CSR_BASE        = 8'd1;
  localparam logic [7:0] CSR_FRAME_WORDS = 8'd2;
  localparam logic [7:0] CSR_STATUS      = 8'd3;
  localparam logic [7:0] CSR_FRAME_COUNT = 8'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_FILL,
    ST_BURST
  } state_t;

endpackage

// File: rtl/ddr3_frame_writer_sync_fifo.sv
// Single-clock word FIFO with occupancy count; head word is presented combinationally on dout.
module ddr3_frame_writer_sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      // simultaneous push and pop leave the count unchanged
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ddr3_frame_writer.sv
// Packs a 24-bit pixel stream 4-per-word and writes whole frames to DDR3 as Avalon-MM bursts.
module ddr3_frame_writer
  import ddr3_frame_writer_pkg::*;
#(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              csr_write,
  input  logic              csr_read,
  input  logic [7:0]        csr_addr,
  input  logic [31:0]       csr_wr_data,
  output logic [31:0]       csr_rd_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [23:0]       pix_data,
  input  logic              pix_sof,
  input  logic              ddr3_avl_ready,
  output logic              ddr3_avl_burstbegin,
  output logic [2:0]        ddr3_avl_size,
  output logic              ddr3_avl_write_req,
  output logic [25:0]       ddr3_avl_addr,
  output logic [127:0]      ddr3_avl_wdata,
  output logic [15:0]       ddr3_avl_be,
  output logic              frame_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t state, state_nxt;

  logic        en, sof_err;
  logic [25:0] base_csr;
  logic [23:0] fw_csr;
  logic [31:0] frame_count, rd_mux;

  logic [25:0] addr_cur;
  logic [23:0] words_rem, rem_after;
  logic [3:0]  burst_n, beat, n_calc;
  logic        fill_ok, beat_done, beat_last, burst_go, done_evt;

  logic                                  acc, in_frame, start_frame, pack, sof_mid, push, flush;
  logic [1:0]                            lane_q, lane;
  logic [PIX_PER_WORD-1:0][LANE_W-1:0]   word_q, word_base, word_nxt;

  logic [WORD_W-1:0] fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;

  logic unused_wr_bits;
  assign unused_wr_bits = ^csr_wr_data[31:26];

  // ---------------- pixel packer ----------------
  assign pix_ready   = en && (state != ST_IDLE) && !fifo_full;
  assign acc         = pix_valid && pix_ready;
  assign in_frame    = (state == ST_FILL) || (state == ST_BURST);
  assign start_frame = acc && pix_sof && (state == ST_WAIT_SOF);
  assign pack        = (acc && in_frame) || (start_frame && (fw_csr != '0));
  assign sof_mid     = acc && in_frame && pix_sof;
  // an sof always restarts the word from lane 0, discarding any partial word
  assign lane        = pix_sof ? 2'd0 : lane_q;
  assign word_base   = pix_sof ? '0 : word_q;
  assign push        = pack && (lane == 2'(PIX_PER_WORD - 1));
  assign flush       = (state == ST_IDLE);

  for (genvar g = 0; g < PIX_PER_WORD; g++) begin : g_lane
    assign word_nxt[g] = (lane == 2'(g)) ? {8'h00, pix_data} : word_base[g];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q <= '0;
      word_q <= '0;
    end else if (flush) begin
      lane_q <= '0;
      word_q <= '0;
    end else if (pack) begin
      lane_q <= lane + 2'd1;
      word_q <= push ? '0 : word_nxt;
    end
  end

  ddr3_frame_writer_sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_sync_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push),
    .din     (word_nxt),
    .pop     (beat_done),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ---------------- burst FSM ----------------
  assign n_calc    = (words_rem < 24'(BURST_LEN)) ? words_rem[3:0] : 4'(BURST_LEN);
  assign fill_ok   = 32'(fifo_count) >= 32'(n_calc);
  assign beat_done = (state == ST_BURST) && ddr3_avl_ready;
  assign beat_last = (beat == burst_n - 4'd1);
  assign rem_after = words_rem - 24'(burst_n);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    burst_go  = 1'b0;
    done_evt  = 1'b0;
    case (state)
      ST_IDLE:     if (en) state_nxt = ST_WAIT_SOF;
      ST_WAIT_SOF: begin
        if (!en) state_nxt = ST_IDLE;
        else if (start_frame) begin
          if (fw_csr == '0) done_evt  = 1'b1;
          else              state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (!en) state_nxt = ST_IDLE;
        else if (fill_ok) begin
          burst_go  = 1'b1;
          state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (beat_done && beat_last) begin
          done_evt  = (rem_after == '0);
          state_nxt = !en ? ST_IDLE : (rem_after == '0) ? ST_WAIT_SOF : ST_FILL;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_cur   <= '0;
      words_rem  <= '0;
      burst_n    <= '0;
      beat       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_evt;
      if (start_frame && (fw_csr != '0)) begin
        addr_cur  <= base_csr;
        words_rem <= fw_csr;
      end
      if (burst_go) begin
        burst_n <= n_calc;
        beat    <= '0;
      end
      if (beat_done) begin
        beat <= beat + 4'd1;
        if (beat_last) begin
          words_rem <= rem_after;
          addr_cur  <= (rem_after == '0) ? base_csr : addr_cur + 26'(burst_n);
        end
      end
    end
  end

  // size is 3 bits wide, so an 8-beat burst is encoded as 3'b000
  assign ddr3_avl_write_req  = (state == ST_BURST);
  assign ddr3_avl_burstbegin = (state == ST_BURST) && (beat == '0);
  assign ddr3_avl_size       = (state == ST_BURST) ? burst_n[2:0] : 3'd0;
  assign ddr3_avl_addr       = (state == ST_BURST) ? addr_cur : 26'd0;
  assign ddr3_avl_wdata      = ((state == ST_BURST) && !fifo_empty) ? fifo_dout : '0;
  assign ddr3_avl_be         = 16'hFFFF;

  // ---------------- CSRs ----------------
  always_comb begin
    rd_mux = '0;
    case (csr_addr)
      CSR_CTRL:        rd_mux = {31'd0, en};
      CSR_BASE:        rd_mux = {6'd0, base_csr};
      CSR_FRAME_WORDS: rd_mux = {8'd0, fw_csr};
      CSR_STATUS:      rd_mux = {30'd0, sof_err, state != ST_IDLE};
      CSR_FRAME_COUNT: rd_mux = frame_count;
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en          <= 1'b0;
      base_csr    <= '0;
      fw_csr      <= '0;
      sof_err     <= 1'b0;
      frame_count <= '0;
      csr_rd_data <= '0;
    end else begin
      if (csr_write) begin
        case (csr_addr)
          CSR_CTRL:        en       <= csr_wr_data[0];
          CSR_BASE:        base_csr <= csr_wr_data[25:0];
          CSR_FRAME_WORDS: fw_csr   <= csr_wr_data[23:0];
          CSR_STATUS:      if (csr_wr_data[1]) sof_err <= 1'b0;
          default: ;
        endcase
      end
      if (sof_mid)  sof_err     <= 1'b1;
      if (done_evt) frame_count <= frame_count + 32'd1;
      csr_rd_data <= csr_read ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_ddr3_frame_writer.sv
// Directed bench for ddr3_frame_writer: frames, short bursts, stalls, sof handling, disable, FIFO full, reset.
module tb_ddr3_frame_writer;
  import ddr3_frame_writer_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         csr_write, csr_read;
  logic [7:0]   csr_addr;
  logic [31:0]  csr_wr_data, csr_rd_data;
  logic         pix_valid, pix_ready, pix_sof;
  logic [23:0]  pix_data;
  logic         ddr3_avl_ready, ddr3_avl_burstbegin, ddr3_avl_write_req;
  logic [2:0]   ddr3_avl_size;
  logic [25:0]  ddr3_avl_addr;
  logic [127:0] ddr3_avl_wdata;
  logic [15:0]  ddr3_avl_be;
  logic         frame_done;

  always #5 clk = ~clk;

  ddr3_frame_writer #(.BURST_LEN(8), .FIFO_DEPTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_write(csr_write), .csr_read(csr_read), .csr_addr(csr_addr),
    .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_sof(pix_sof),
    .ddr3_avl_ready(ddr3_avl_ready), .ddr3_avl_burstbegin(ddr3_avl_burstbegin),
    .ddr3_avl_size(ddr3_avl_size), .ddr3_avl_write_req(ddr3_avl_write_req),
    .ddr3_avl_addr(ddr3_avl_addr), .ddr3_avl_wdata(ddr3_avl_wdata),
    .ddr3_avl_be(ddr3_avl_be), .frame_done(frame_done)
  );

  int n_chk = 0, n_fail = 0;
  bit rand_ready = 1'b0;

  // beat recorder, sampled on the falling edge
  logic [25:0]  q_addr[$];
  logic [2:0]   q_size[$];
  bit           q_bb[$];
  logic [127:0] q_data[$];
  int bb_cnt = 0, done_cnt = 0, stall_err = 0;
  bit           stalled_prev = 1'b0;
  logic [25:0]  p_addr;
  logic [2:0]   p_size;
  logic         p_bb;
  logic [127:0] p_data;

  always @(negedge clk) begin
    if (reset_n && stalled_prev &&
        (!ddr3_avl_write_req || ddr3_avl_addr !== p_addr || ddr3_avl_size !== p_size ||
         ddr3_avl_burstbegin !== p_bb || ddr3_avl_wdata !== p_data))
      stall_err++;
    if (ddr3_avl_write_req && ddr3_avl_ready) begin
      q_addr.push_back(ddr3_avl_addr);
      q_size.push_back(ddr3_avl_size);
      q_bb.push_back(ddr3_avl_burstbegin);
      q_data.push_back(ddr3_avl_wdata);
      if (ddr3_avl_burstbegin) bb_cnt++;
    end
    if (frame_done) done_cnt++;
    stalled_prev = reset_n && ddr3_avl_write_req && !ddr3_avl_ready;
    p_addr = ddr3_avl_addr;
    p_size = ddr3_avl_size;
    p_bb   = ddr3_avl_burstbegin;
    p_data = ddr3_avl_wdata;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [127:0] exp_w[$];

  function automatic logic [127:0] pw(input logic [23:0] p0, p1, p2, p3);
    return {8'h00, p3, 8'h00, p2, 8'h00, p1, 8'h00, p0};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) ddr3_avl_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
    csr_write = 1'b1; csr_addr = a; csr_wr_data = d;
    step();
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [7:0] a, output logic [31:0] d);
    csr_read = 1'b1; csr_addr = a;
    step();
    csr_read = 1'b0;
    d = csr_rd_data;
  endtask

  task automatic send_pix(input logic [23:0] start, input int n, input int sof_a, input int sof_b);
    for (int i = 0; i < n; i++) begin
      bit got = 1'b0;
      int t = 0;
      pix_valid = 1'b1;
      pix_data  = start + 24'(i);
      pix_sof   = (i == sof_a) || (i == sof_b);
      while (!got) begin
        got = pix_ready;
        step();
        t++;
        if (!got && t > 2000) begin
          chk("pix_timeout", 0, 1);
          pix_valid = 1'b0; pix_sof = 1'b0;
          return;
        end
      end
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 3000) begin step(); t++; end
    chk("frame_done_wait", 128'(done_cnt >= target), 1);
  endtask

  task automatic wait_req(input logic v);
    int t = 0;
    while (ddr3_avl_write_req !== v && t < 500) begin step(); t++; end
    chk("write_req_wait", ddr3_avl_write_req, v);
  endtask

  task automatic add_words(input logic [23:0] s, input int n);
    for (int j = 0; j < n; j++)
      exp_w.push_back(pw(s + 24'(4*j), s + 24'(4*j+1), s + 24'(4*j+2), s + 24'(4*j+3)));
  endtask

  task automatic chk_beats(input string tag, input int b0);
    int errs = 0;
    for (int j = 0; j < exp_w.size(); j++)
      if (b0 + j >= q_data.size() || q_data[b0+j] !== exp_w[j]) errs++;
    chk({tag, "_beats"}, q_data.size() - b0, exp_w.size());
    chk({tag, "_data"}, errs, 0);
    exp_w.delete();
  endtask

  initial begin
    logic [31:0] rd;
    int b0, bb0, errs;

    reset_n = 1'b0; csr_write = 1'b0; csr_read = 1'b0; csr_addr = '0; csr_wr_data = '0;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0; ddr3_avl_ready = 1'b0;
    #1;
    chk("rst_write_req", ddr3_avl_write_req, 0);
    chk("rst_burstbegin", ddr3_avl_burstbegin, 0);
    chk("rst_be", ddr3_avl_be, 16'hFFFF);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_frame_done", frame_done, 0);
    repeat (3) step();
    reset_n = 1'b1;
    step();
    csr_rd(CSR_STATUS, rd);      chk("rst_status", rd, 0);
    csr_rd(CSR_FRAME_COUNT, rd); chk("rst_fcount", rd, 0);

    // 16-word frame: two full bursts at 0x100 and 0x108
    ddr3_avl_ready = 1'b1;
    csr_wr(CSR_BASE, 32'h100);
    csr_wr(CSR_FRAME_WORDS, 32'd16);
    csr_wr(CSR_CTRL, 32'd1);
    b0 = q_data.size(); bb0 = bb_cnt;
    send_pix(24'h010000, 64, 0, -1);
    wait_done(1);
    add_words(24'h010000, 16);
    chk_beats("t1", b0);
    chk("t1_bb_cnt", bb_cnt - bb0, 2);
    chk("t1_addr0", q_addr[b0], 26'h100);
    chk("t1_size0_8beats", q_size[b0], 3'd0);
    chk("t1_addr8", q_addr[b0+8], 26'h108);
    chk("t1_bb8", q_bb[b0+8], 1);
    csr_rd(CSR_FRAME_COUNT, rd); chk("t1_fcount", rd, 1);

    // 10-word frame: bursts of 8 then 2
    csr_wr(CSR_FRAME_WORDS, 32'd10);
    b0 = q_data.size(); bb0 = bb_cnt;
    send_pix(24'h020000, 40, 0, -1);
    wait_done(2);
    add_words(24'h020000, 10);
    chk_beats("t2", b0);
    chk("t2_bb_cnt", bb_cnt - bb0, 2);
    chk("t2_bb1", q_bb[b0+1], 0);
    chk("t2_size_tail", q_size[b0+8], 3'd2);
    chk("t2_addr_tail", q_addr[b0+8], 26'h108);
    chk("t2_addr_tail_beat2", q_addr[b0+9], 26'h108);

    // random backpressure during the burst
    csr_wr(CSR_FRAME_WORDS, 32'd8);
    b0 = q_data.size();
    rand_ready = 1'b1;
    send_pix(24'h030000, 32, 0, -1);
    wait_done(3);
    rand_ready = 1'b0; ddr3_avl_ready = 1'b1;
    add_words(24'h030000, 8);
    chk_beats("t3", b0);
    chk("t3_stall_stable", stall_err, 0);

    // non-sof pixels before sof are dropped
    csr_wr(CSR_FRAME_WORDS, 32'd4);
    b0 = q_data.size();
    send_pix(24'h040000, 5, -1, -1);
    send_pix(24'h040100, 16, 0, -1);
    wait_done(4);
    add_words(24'h040100, 4);
    chk_beats("t4_drop", b0);
    csr_rd(CSR_STATUS, rd); chk("t4_status_clean", rd, 32'h1);

    // sof on the 6th pixel restarts packing at lane 0
    b0 = q_data.size();
    send_pix(24'h050000, 17, 0, 5);
    wait_done(5);
    exp_w.push_back(pw(24'h050000, 24'h050001, 24'h050002, 24'h050003));
    add_words(24'h050005, 3);
    chk_beats("t4_sof", b0);
    csr_rd(CSR_STATUS, rd); chk("t4_sof_err", rd, 32'h3);
    csr_wr(CSR_STATUS, 32'h2);
    csr_rd(CSR_STATUS, rd); chk("t4_w1c", rd, 32'h1);

    // zero-length frame: frame_done on sof with no traffic
    csr_wr(CSR_FRAME_WORDS, 32'd0);
    b0 = q_data.size();
    send_pix(24'h0A0000, 1, 0, -1);
    wait_done(6);
    chk("t4_zero_len_beats", q_data.size() - b0, 0);

    // enable dropped mid-burst: burst finishes, then idle
    csr_wr(CSR_FRAME_WORDS, 32'd16);
    ddr3_avl_ready = 1'b0;
    b0 = q_data.size();
    send_pix(24'h060000, 32, 0, -1);
    wait_req(1'b1);
    csr_wr(CSR_CTRL, 32'd0);
    chk("t5_req_held", ddr3_avl_write_req, 1);
    ddr3_avl_ready = 1'b1;
    wait_req(1'b0);
    step();
    add_words(24'h060000, 8);
    chk_beats("t5", b0);
    chk("t5_pix_ready", pix_ready, 0);
    csr_rd(CSR_STATUS, rd); chk("t5_busy", rd, 0);
    chk("t5_no_done", done_cnt, 6);

    // FIFO fills to 32 words under backpressure; address wraps modulo 2^26
    csr_wr(CSR_BASE, 32'h3FFFFF8);
    csr_wr(CSR_FRAME_WORDS, 32'd64);
    csr_wr(CSR_CTRL, 32'd1);
    ddr3_avl_ready = 1'b0;
    b0 = q_data.size(); bb0 = bb_cnt;
    send_pix(24'h070000, 128, 0, -1);
    pix_valid = 1'b1; pix_data = 24'h070080; pix_sof = 1'b0;
    step(); step();
    chk("t6_full_pix_ready", pix_ready, 0);
    chk("t6_req_held", ddr3_avl_write_req, 1);
    ddr3_avl_ready = 1'b1;
    send_pix(24'h070080, 128, -1, -1);
    wait_done(7);
    add_words(24'h070000, 64);
    chk_beats("t6", b0);
    errs = 0;
    for (int j = 0; j < 64; j++)
      if (q_addr[b0+j] !== 26'(26'h3FFFFF8 + 26'(8 * (j / 8)))) errs++;
    chk("t6_addr_wrap", errs, 0);
    chk("t6_bb_cnt", bb_cnt - bb0, 8);
    csr_rd(CSR_FRAME_COUNT, rd); chk("t6_fcount", rd, 7);

    // reset in the middle of a stalled burst
    ddr3_avl_ready = 1'b0;
    send_pix(24'h080000, 32, 0, -1);
    wait_req(1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_write_req", ddr3_avl_write_req, 0);
    chk("rst_mid_burstbegin", ddr3_avl_burstbegin, 0);
    chk("rst_mid_addr", ddr3_avl_addr, 0);
    chk("rst_mid_pix_ready", pix_ready, 0);
    step(); step();
    reset_n = 1'b1;
    step();
    csr_rd(CSR_CTRL, rd);        chk("rst_mid_ctrl", rd, 0);
    csr_rd(CSR_FRAME_COUNT, rd); chk("rst_mid_fcount", rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
